// File: rtl/divider_pkg.sv
// Shared types and widths for the repeated-subtraction divider.
// Imported by the divider top and its subtractor.
package divider_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor.sv
// Combinational a-b for the working remainder.
// borrow low means a >= b.
module subtractor
  import divider_pkg::*;
(
  input  logic [DIVIDEND_W-1:0] a,
  input  logic [DIVIDEND_W-1:0] b,
  output logic [DIVIDEND_W-1:0] diff,
  output logic                  borrow
);

  // One extra bit catches the borrow out of the MSB
  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/divider.sv
// Unsigned 8/4 divider by repeated subtraction.
// One subtract per cycle; outputs registered.
module divider
  import divider_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_by_zero_o
);

  state_t                state;
  logic [DIVIDEND_W-1:0] r;
  logic [DIVIDEND_W-1:0] q;
  logic [DIVISOR_W-1:0]  d;
  logic [DIVIDEND_W-1:0] diff;
  logic                  borrow;

  subtractor u_sub (
    .a      (r),
    .b      ({{(DIVIDEND_W-DIVISOR_W){1'b0}}, d}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign quotient_o  = q;
  assign remainder_o = r[DIVISOR_W-1:0];

  // FSM, datapath registers and status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      r             <= '0;
      q             <= '0;
      d             <= '0;
      div_by_zero_o <= 1'b0;
      ready_o       <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            r             <= dividend_i;
            d             <= divisor_i;
            q             <= '0;
            div_by_zero_o <= 1'b0;
            state         <= RUN;
            ready_o       <= 1'b0;
            busy_o        <= 1'b1;
          end
        end
        RUN: begin
          if (d == '0) begin
            div_by_zero_o <= 1'b1;
            q             <= '1;
            r             <= '0;
            state         <= DONE;
            busy_o        <= 1'b0;
            done_o        <= 1'b1;
          end else if (!borrow) begin
            r <= diff;
            q <= q + 8'd1;
          end else begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_o  <= 1'b0;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
